// File: rtl/fsm_controller_if.sv
// fsm_controller_if
//   Bundles the decoder-facing inputs and datapath strobes of the RISC
//   control unit.
//   master : the controller (consumes s/opcode/op, drives everything else)
//   slave  : decoder/datapath side (drives s/opcode/op, consumes strobes)
//   Signals:
//     s       start pulse, sampled only while idle
//     opcode  instruction [15:13]
//     op      instruction [12:11]
//     w       1 = idle, ready for s
//     nsel    register select to decoder (00 Rm, 01 Rd, 10 Rn)
//     loada/loadb/loadc/loads  datapath register / status loads
//     asel    ALU A input forced to zero
//     bsel    ALU B input is sximm5
//     vsel    write-back source (00 C, 10 sximm8)
//     write   register file write enable
interface fsm_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [1:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] vsel;
  logic       write;

  modport master (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
  );

  modport slave (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
  );
endinterface

// File: rtl/fsm_controller.sv
// fsm_controller
//   Multi-cycle Moore control unit for the simple RISC machine. Accepts an
//   instruction on a start pulse, latches {opcode,op}, then sequences the
//   register reads, ALU execution and write-back / status update.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; returns to WAIT, clears the latch
//     bus    fsm_controller_if.master (decoder fields in, strobes out)
module fsm_controller (
  input  logic                      clk,
  input  logic                      reset,
  fsm_controller_if.master          bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_COMPARE,
    S_WRITE_REG
  } state_t;

  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;

  state_t     state;
  state_t     next;
  logic [4:0] instr;

  logic       w;
  logic [1:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic [1:0] vsel;
  logic       write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      instr <= '0;
    end else begin
      state <= next;
      // Dispatch works from this copy so the decoder may move on.
      if (state == S_WAIT && bus.s)
        instr <= {bus.opcode, bus.op};
    end
  end

  always_comb begin
    next  = state;
    w     = 1'b0;
    nsel  = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    vsel  = 2'b00;
    write = 1'b0;

    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (bus.s)
          next = S_DECODE;
      end
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:             next = S_WRITE_IMM;
          I_MOV_REG, I_MVN:      next = S_GET_B;
          I_ADD, I_CMP, I_AND:   next = S_GET_A;
          default:               next = S_WAIT;
        endcase
      end
      S_WRITE_IMM: begin
        nsel  = 2'b10;
        vsel  = 2'b10;
        write = 1'b1;
        next  = S_WAIT;
      end
      S_GET_A: begin
        nsel  = 2'b10;
        loada = 1'b1;
        next  = S_GET_B;
      end
      S_GET_B: begin
        nsel  = 2'b00;
        loadb = 1'b1;
        next  = (instr == I_CMP) ? S_COMPARE : S_EXEC;
      end
      S_EXEC: begin
        loadc = 1'b1;
        // MOV-reg passes B through the ALU as 0 + sh(Rm).
        asel  = (instr == I_MOV_REG);
        next  = S_WRITE_REG;
      end
      S_COMPARE: begin
        loads = 1'b1;
        next  = S_WAIT;
      end
      S_WRITE_REG: begin
        nsel  = 2'b01;
        vsel  = 2'b00;
        write = 1'b1;
        next  = S_WAIT;
      end
      default: next = S_WAIT;
    endcase
  end

  assign bus.w     = w;
  assign bus.nsel  = nsel;
  assign bus.loada = loada;
  assign bus.loadb = loadb;
  assign bus.loadc = loadc;
  assign bus.loads = loads;
  assign bus.asel  = asel;
  assign bus.bsel  = 1'b0;
  assign bus.vsel  = vsel;
  assign bus.write = write;

endmodule
